// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes, FSM encoding and counter sizing for the multiply/divide unit
package mdu_pkg;

  localparam logic [2:0] MDU_NONE  = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_MULTU = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_DIVU  = 3'b100;
  localparam logic [2:0] MDU_MTHI  = 3'b101;
  localparam logic [2:0] MDU_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mduState_t;

  // ceil(log2(width)): enough bits to count steps 0..width-1
  function automatic int ctrWidth(input int width);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < width) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - execute-stage to multiply/divide unit signal bundle
interface mdu_hilo_if #(parameter int WIDTH = 32);

  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             stall_o;
  logic             busy_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  stall_o, busy_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output stall_o, busy_o, hi_o, lo_o
  );

endinterface

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement negation
module mdu_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mdu_hilo_if.slave bus
);

  localparam int CW = ctrWidth(WIDTH);

  mduState_t state, stateNext;

  logic             isMulDiv, opSigned, opDiv;
  logic             issue, finish, writeHi, writeLo, stall;
  logic [WIDTH-1:0] aMag, bMag;
  logic [CW-1:0]    count;

  logic [2*WIDTH-1:0] shiftReg, stepNext, prodFix;
  logic [WIDTH-1:0]   operandB, dividendRaw, hiReg, loReg;
  logic [WIDTH-1:0]   quotFix, remFix, finalHi, finalLo;
  logic               isDiv, divZero, signLo, signHi;

  logic [WIDTH:0]   addA, addB;
  logic [WIDTH+1:0] addFull;
  logic             divOk;

  always_comb begin
    isMulDiv = bus.op_i inside {MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU};
    opSigned = (bus.op_i == MDU_MULT) || (bus.op_i == MDU_DIV);
    opDiv    = (bus.op_i == MDU_DIV)  || (bus.op_i == MDU_DIVU);
  end

  mdu_negate #(.WIDTH(WIDTH)) negA (
    .value(bus.a_i), .negate(opSigned & bus.a_i[WIDTH-1]), .result(aMag)
  );
  mdu_negate #(.WIDTH(WIDTH)) negB (
    .value(bus.b_i), .negate(opSigned & bus.b_i[WIDTH-1]), .result(bMag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    writeHi   = 1'b0;
    writeLo   = 1'b0;
    case (state)
      IDLE: begin
        stall = bus.start_i & isMulDiv;
        if (bus.start_i && !bus.flush_i) begin
          if (isMulDiv) begin
            issue     = 1'b1;
            stateNext = BUSY;
          end
          writeHi = (bus.op_i == MDU_MTHI);
          writeLo = (bus.op_i == MDU_MTLO);
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.flush_i) begin
          stateNext = IDLE;
        end else if (count == CW'(WIDTH - 1)) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Shared adder: multiply adds the multiplicand when the low bit is set;
  // divide subtracts the divisor, carry-out meaning the trial did not borrow.
  always_comb begin
    addA     = isDiv ? shiftReg[2*WIDTH-1:WIDTH-1] : {1'b0, shiftReg[2*WIDTH-1:WIDTH]};
    addB     = isDiv ? ~{1'b0, operandB} : (shiftReg[0] ? {1'b0, operandB} : '0);
    addFull  = {1'b0, addA} + {1'b0, addB} + {{(WIDTH+1){1'b0}}, isDiv};
    divOk    = addFull[WIDTH+1];
    stepNext = isDiv ?
      {(divOk ? addFull[WIDTH-1:0] : shiftReg[2*WIDTH-2:WIDTH-1]), shiftReg[WIDTH-2:0], divOk} :
      {addFull[WIDTH:0], shiftReg[WIDTH-1:1]};
  end

  mdu_negate #(.WIDTH(2*WIDTH)) negProd (
    .value(stepNext), .negate(signLo), .result(prodFix)
  );
  mdu_negate #(.WIDTH(WIDTH)) negQuot (
    .value(stepNext[WIDTH-1:0]), .negate(signLo), .result(quotFix)
  );
  mdu_negate #(.WIDTH(WIDTH)) negRem (
    .value(stepNext[2*WIDTH-1:WIDTH]), .negate(signHi), .result(remFix)
  );

  // MIN / -1 falls out of the magnitude path; only divide-by-zero is overridden.
  always_comb begin
    finalHi = divZero ? dividendRaw : (isDiv ? remFix  : prodFix[2*WIDTH-1:WIDTH]);
    finalLo = divZero ? '1          : (isDiv ? quotFix : prodFix[WIDTH-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      shiftReg    <= '0;
      operandB    <= '0;
      dividendRaw <= '0;
      isDiv       <= 1'b0;
      divZero     <= 1'b0;
      signLo      <= 1'b0;
      signHi      <= 1'b0;
      hiReg       <= '0;
      loReg       <= '0;
    end else begin
      if (issue) begin
        count       <= '0;
        shiftReg    <= {{WIDTH{1'b0}}, aMag};
        operandB    <= bMag;
        dividendRaw <= bus.a_i;
        isDiv       <= opDiv;
        divZero     <= opDiv && (bus.b_i == '0);
        signLo      <= opSigned & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
        signHi      <= opSigned & bus.a_i[WIDTH-1];
      end else if (state == BUSY) begin
        count    <= count + CW'(1);
        shiftReg <= stepNext;
      end
      if (finish) begin
        hiReg <= finalHi;
        loReg <= finalLo;
      end else begin
        if (writeHi) hiReg <= bus.a_i;
        if (writeLo) loReg <= bus.a_i;
      end
    end
  end

  assign bus.stall_o = stall;
  assign bus.busy_o  = (state != IDLE);
  assign bus.hi_o    = hiReg;
  assign bus.lo_o    = loReg;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo at WIDTH=32 and WIDTH=8
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sel8, tbStart, tbFlush;
  logic [2:0]  tbOp;
  logic [31:0] tbA, tbB;
  int checks = 0;
  int failures = 0;

  mdu_hilo_if #(.WIDTH(32)) m32 ();
  mdu_hilo_if #(.WIDTH(8))  m8 ();

  mdu_hilo #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(m32.slave));
  mdu_hilo #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(m8.slave));

  assign m32.start_i = tbStart & ~sel8;
  assign m32.flush_i = tbFlush & ~sel8;
  assign m32.op_i    = tbOp;
  assign m32.a_i     = tbA;
  assign m32.b_i     = tbB;
  assign m8.start_i  = tbStart & sel8;
  assign m8.flush_i  = tbFlush & sel8;
  assign m8.op_i     = tbOp;
  assign m8.a_i      = tbA[7:0];
  assign m8.b_i      = tbB[7:0];

  logic        curStall, curBusy;
  logic [31:0] curHi, curLo;
  assign curStall = sel8 ? m8.stall_o : m32.stall_o;
  assign curBusy  = sel8 ? m8.busy_o  : m32.busy_o;
  assign curHi    = sel8 ? {24'b0, m8.hi_o} : m32.hi_o;
  assign curLo    = sel8 ? {24'b0, m8.lo_o} : m32.lo_o;

  // Reference: plain integer arithmetic on w-bit values held in 64-bit variables
  function automatic void refModel(input int w, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi, output logic [31:0] lo);
    longint mask, ua, ub, sa, sb, minVal;
    logic [63:0] p;
    mask   = (longint'(1) << w) - 1;
    minVal = -(longint'(1) << (w - 1));
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
    sb = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
    hi = '0;
    lo = '0;
    if (op == MDU_MULT || op == MDU_MULTU) begin
      p  = (op == MDU_MULT) ? sa * sb : ua * ub;
      hi = 32'((p >> w) & mask);
      lo = 32'(p & mask);
    end else if (ub == 0) begin
      lo = 32'(mask);
      hi = 32'(ua);
    end else if (op == MDU_DIV && sa == minVal && sb == -1) begin
      lo = 32'(ua);
      hi = '0;
    end else if (op == MDU_DIV) begin
      lo = 32'((sa / sb) & mask);
      hi = 32'((sa % sb) & mask);
    end else begin
      lo = 32'(ua / ub);
      hi = 32'(ua % ub);
    end
  endfunction

  // Issue a mult/div in IDLE, count stall cycles, and return sampling in the DONE cycle
  task automatic runOp(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input bit holdStart);
    int stalls, w;
    w = sel8 ? 8 : 32;
    @(negedge clk);
    tbOp = op; tbA = a; tbB = b; tbStart = 1'b1;
    #1;
    stalls = 0;
    while (curStall && stalls < 100) begin
      stalls++;
      @(negedge clk);
      if (!holdStart) tbStart = 1'b0;
      #1;
    end
    checks++;
    if (stalls !== w + 1)
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stalls, w + 1);
    if (stalls !== w + 1) failures++;
    checks++;
    if (curBusy !== 1'b1) begin
      failures++;
      $display("FAIL %s done_busy: got %b expected 1", name, curBusy);
    end
    checks++;
    if (curHi !== expHi || curLo !== expLo) begin
      failures++;
      $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, curHi, curLo, expHi, expLo);
    end
  endtask

  task automatic runRand(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    refModel(sel8 ? 8 : 32, op, a, b, eh, el);
    runOp(name, op, a, b, eh, el, 1'b0);
  endtask

  task automatic mtWrite(input string name, input logic [2:0] op, input logic [31:0] a, input logic flush,
                         input logic [31:0] expHi, input logic [31:0] expLo);
    @(negedge clk);
    tbOp = op; tbA = a; tbFlush = flush; tbStart = 1'b1;
    #1;
    checks++;
    if (curStall !== 1'b0) begin
      failures++;
      $display("FAIL %s stall: got %b expected 0", name, curStall);
    end
    @(negedge clk);
    tbStart = 1'b0; tbFlush = 1'b0;
    #1;
    checks++;
    if (curHi !== expHi || curLo !== expLo) begin
      failures++;
      $display("FAIL %s regs: got hi=%h lo=%h expected hi=%h lo=%h", name, curHi, curLo, expHi, expLo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel8 = 1'b0; tbStart = 1'b0; tbFlush = 1'b0; tbOp = MDU_NONE; tbA = '0; tbB = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m32.hi_o !== 32'h0 || m32.lo_o !== 32'h0 || m32.busy_o !== 1'b0 || m32.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset32: got hi=%h lo=%h busy=%b stall=%b expected zeros", m32.hi_o, m32.lo_o, m32.busy_o, m32.stall_o);
    end
    checks++;
    if (m8.hi_o !== 8'h0 || m8.lo_o !== 8'h0 || m8.busy_o !== 1'b0 || m8.stall_o !== 1'b0) begin
      failures++;
      $display("FAIL reset8: got hi=%h lo=%h busy=%b stall=%b expected zeros", m8.hi_o, m8.lo_o, m8.busy_o, m8.stall_o);
    end
  endtask

  task automatic test_mthilo();
    mtWrite("mthi", MDU_MTHI, 32'hAAAA5555, 1'b0, 32'hAAAA5555, 32'h0);
    mtWrite("mtlo", MDU_MTLO, 32'h0000FFFF, 1'b0, 32'hAAAA5555, 32'h0000FFFF);
    mtWrite("mthi_flushed", MDU_MTHI, 32'h12121212, 1'b1, 32'hAAAA5555, 32'h0000FFFF);
    mtWrite("mtlo_flushed", MDU_MTLO, 32'h34343434, 1'b1, 32'hAAAA5555, 32'h0000FFFF);
  endtask

  task automatic flushAt(input string name, input int iteration);
    @(negedge clk);
    tbOp = MDU_DIV; tbA = 32'd1000; tbB = 32'd7; tbStart = 1'b1;
    repeat (iteration) begin
      @(negedge clk);
      tbStart = 1'b0;
    end
    tbFlush = 1'b1;
    @(negedge clk);
    tbFlush = 1'b0;
    #1;
    checks++;
    if (curBusy !== 1'b0 || curStall !== 1'b0 || curHi !== 32'hAAAA5555 || curLo !== 32'h0000FFFF) begin
      failures++;
      $display("FAIL %s: got busy=%b stall=%b hi=%h lo=%h expected busy=0 stall=0 hi=aaaa5555 lo=0000ffff",
               name, curBusy, curStall, curHi, curLo);
    end
  endtask

  task automatic test_flush();
    flushAt("flush_iter10", 10);
    flushAt("flush_last_step", 32);
  endtask

  task automatic test_directed32();
    runOp("mult_neg3x5", MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    runOp("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    runOp("div_neg7by2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    runOp("divu_by0", MDU_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 1'b0);
    runOp("div_by0", MDU_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
    runOp("div_overflow", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
  endtask

  task automatic test_back_to_back();
    runOp("b2b_hold", MDU_MULT, 32'd123, 32'hFFFFFF00, 32'hFFFFFFFF, 32'hFFFF8500, 1'b1);
    @(negedge clk);
    tbStart = 1'b0;
    #1;
    checks++;
    if (curBusy !== 1'b0) begin
      failures++;
      $display("FAIL done_retrigger: got busy=%b expected 0", curBusy);
    end
    runOp("b2b_first", MDU_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 1'b0);
    runOp("b2b_second", MDU_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    tbOp = MDU_MULT; tbA = 32'd7; tbB = 32'd9; tbStart = 1'b1;
    @(negedge clk);
    tbStart = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (curBusy !== 1'b0 || curHi !== 32'h0 || curLo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: got busy=%b hi=%h lo=%h expected busy=0 hi=0 lo=0", curBusy, curHi, curLo);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random(input int n);
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(1, 4));
      a  = ($urandom_range(0, 7) == 0) ? (sel8 ? 32'h80 : 32'h80000000) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      runRand(sel8 ? "rand8" : "rand32", op, a, b);
    end
  endtask

  task automatic test_width8();
    sel8 = 1'b1;
    runOp("w8_mult_neg3x5", MDU_MULT, 32'hFD, 32'h05, 32'hFF, 32'hF1, 1'b0);
    runOp("w8_multu_max", MDU_MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    test_random(12);
    sel8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mthilo();
    test_flush();
    test_directed32();
    test_back_to_back();
    test_reset_mid();
    test_random(16);
    test_width8();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
